// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit CPU datapath. One 16-bit instruction is
// executed per clock: decode, operand read, ALU and data-memory read are all
// combinational from `inst`; register, memory and flag writes commit together
// on the next rising edge of clk.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset (clears registers and flags,
//                 data memory is not cleared)
//   inst[15:0]    instruction: [15:12] opcode, [11:8] rd, [7:4] rs1,
//                 [3:0] rs2, [7:0] imm
//   flags[2:0]    status register {zero, carry, negative}
//   dbg_reg_sel   register index for dbg_reg
//   dbg_reg       combinational read of register[dbg_reg_sel]
//   dbg_mem_addr  memory address for dbg_mem
//   dbg_mem       combinational read of memory[dbg_mem_addr]
//
// Configuration macro: CPU_CORE_FLAGS_EN
//   defined   -> status flag register is built and drives `flags`
//   undefined -> no flag register, `flags` is tied to 3'b000
//
// There is no FSM: the core is a pure single-cycle datapath.
module cpu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst,
  output logic [2:0]  flags,
  input  logic [3:0]  dbg_reg_sel,
  output logic [7:0]  dbg_reg,
  input  logic [7:0]  dbg_mem_addr,
  output logic [7:0]  dbg_mem
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_INC = 4'h8, OP_DEC = 4'h9, OP_MOV = 4'hA, OP_NP1 = 4'hB,
    OP_NP2 = 4'hC, OP_ST  = 4'hD, OP_LD  = 4'hE, OP_LDI = 4'hF
  } opcode_e;

  // Architectural state
  logic [7:0] regs_q [16];
  logic [7:0] mem_q  [256];

  // Decode
  opcode_e    op;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [7:0] imm;

  assign op  = opcode_e'(inst[15:12]);
  assign rd  = inst[11:8];
  assign rs1 = inst[7:4];
  assign rs2 = inst[3:0];
  assign imm = inst[7:0];

  // Operands are read before any write of this cycle commits, so rd == rs1
  // naturally sees the old value.
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] mem_rdata;

  assign a         = regs_q[rs1];
  assign b         = regs_q[rs2];
  assign mem_rdata = mem_q[a];

  // ALU: bit 8 of alu_res9 is the carry/borrow/shifted-out bit for every op,
  // and is 0 for the logic ops and MOV.
  logic [8:0] alu_res9;
  logic [7:0] alu_res;

  always_comb begin
    alu_res9 = {1'b0, a};
    case (op)
      OP_ADD:  alu_res9 = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_res9 = {1'b0, a} - {1'b0, b};   // bit 8 set when a < b
      OP_AND:  alu_res9 = {1'b0, a & b};
      OP_OR:   alu_res9 = {1'b0, a | b};
      OP_XOR:  alu_res9 = {1'b0, a ^ b};
      OP_NOT:  alu_res9 = {1'b0, ~a};
      OP_SHL:  alu_res9 = {a, 1'b0};
      OP_SHR:  alu_res9 = {a[0], 1'b0, a[7:1]};
      OP_INC:  alu_res9 = {1'b0, a} + 9'd1;
      OP_DEC:  alu_res9 = {1'b0, a} - 9'd1;        // bit 8 set when a == 0
      OP_MOV:  alu_res9 = {1'b0, a};
      default: alu_res9 = {1'b0, a};
    endcase
  end

  assign alu_res = alu_res9[7:0];

  // Write-back control
  logic       reg_we;
  logic       mem_we;
  logic       flag_we;
  logic [7:0] rf_wdata;
  logic [2:0] flags_d;

  always_comb begin
    reg_we   = 1'b1;
    rf_wdata = alu_res;
    case (op)
      OP_NP1, OP_NP2, OP_ST: reg_we = 1'b0;
      OP_LD:                 rf_wdata = mem_rdata;
      OP_LDI:                rf_wdata = imm;
      default:               rf_wdata = alu_res;
    endcase
  end

  assign mem_we  = (op == OP_ST);
  assign flag_we = (inst[15:12] <= 4'hA);
  assign flags_d = {(alu_res == 8'h00), alu_res9[8], alu_res[7]};

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else if (reg_we) begin
      regs_q[rd] <= rf_wdata;
    end
  end

  // Data memory is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[a] <= b;
  end

`ifdef CPU_CORE_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       flags_q <= 3'b000;
    else if (flag_we) flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^{flags_d, flag_we};
  assign flags        = 3'b000;
`endif

  // Debug read ports
  assign dbg_reg = regs_q[dbg_reg_sel];
  assign dbg_mem = mem_q[dbg_mem_addr];

endmodule

// File: tb/tb_cpu_core.sv
// Directed testbench for cpu_core: a table of {instruction, register to
// inspect, expected register value, expected flags} applied one per clock,
// followed by hand-written sequences for memory, asynchronous reset and
// first-edge-after-reset behaviour. Expected flags collapse to 3'b000 when
// the core is built without CPU_CORE_FLAGS_EN.
module tb_cpu_core;

`ifdef CPU_CORE_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst;
  logic [2:0]  flags;
  logic [3:0]  dbg_reg_sel;
  logic [7:0]  dbg_reg;
  logic [7:0]  dbg_mem_addr;
  logic [7:0]  dbg_mem;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .flags        (flags),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg      (dbg_reg),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem      (dbg_mem)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] exp_fl(input logic [2:0] f);
    return FLAGS_EN ? f : 3'b000;
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Driver: present one instruction at the falling edge, let the rising
  // edge commit it, then sample 1 time unit later.
  task automatic exec(input logic [15:0] ins, input logic [3:0] sel, input logic [7:0] maddr);
    @(negedge clk);
    inst         = ins;
    dbg_reg_sel  = sel;
    dbg_mem_addr = maddr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  sel;
    logic [7:0]  exp_reg;
    logic [2:0]  exp_flags;  // {zero, carry, negative}
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    // Flags are {z,c,n}; comments show the architectural effect.
    vecs[0]  = '{16'hF10A, 4'h1, 8'h0A, 3'b000}; // LDI x1=10
    vecs[1]  = '{16'hF202, 4'h2, 8'h02, 3'b000}; // LDI x2=2
    vecs[2]  = '{16'h0112, 4'h1, 8'h0C, 3'b000}; // ADD x1=x1+x2 (rd==rs1)
    vecs[3]  = '{16'hF203, 4'h2, 8'h03, 3'b000}; // LDI x2=3
    vecs[4]  = '{16'h1112, 4'h1, 8'h09, 3'b000}; // SUB x1=12-3
    vecs[5]  = '{16'hF405, 4'h4, 8'h05, 3'b000}; // LDI x4=5
    vecs[6]  = '{16'hF506, 4'h5, 8'h06, 3'b000}; // LDI x5=6
    vecs[7]  = '{16'h1645, 4'h6, 8'hFF, 3'b011}; // SUB x6=5-6 borrow
    vecs[8]  = '{16'hF104, 4'h1, 8'h04, 3'b011}; // LDI x1=4, flags hold
    vecs[9]  = '{16'hF20A, 4'h2, 8'h0A, 3'b011}; // LDI x2=10
    vecs[10] = '{16'hD012, 4'h0, 8'h00, 3'b011}; // ST mem[4]=10, x0 untouched
    vecs[11] = '{16'hE310, 4'h3, 8'h0A, 3'b011}; // LD x3=mem[4]
    vecs[12] = '{16'hF7FF, 4'h7, 8'hFF, 3'b011}; // LDI x7=FF
    vecs[13] = '{16'hF801, 4'h8, 8'h01, 3'b011}; // LDI x8=01
    vecs[14] = '{16'h0978, 4'h9, 8'h00, 3'b110}; // ADD FF+01 wraps
    vecs[15] = '{16'hAB10, 4'hB, 8'h04, 3'b000}; // MOV xB=x1
    vecs[16] = '{16'h7A80, 4'hA, 8'h00, 3'b110}; // SHR 01 -> 0, carry out
    vecs[17] = '{16'h6B70, 4'hB, 8'hFE, 3'b011}; // SHL FF -> FE, carry out
    vecs[18] = '{16'h2C78, 4'hC, 8'h01, 3'b000}; // AND FF&01
    vecs[19] = '{16'h3D12, 4'hD, 8'h0E, 3'b000}; // OR 04|0A
    vecs[20] = '{16'h4E77, 4'hE, 8'h00, 3'b100}; // XOR self -> 0
    vecs[21] = '{16'h5F80, 4'hF, 8'hFE, 3'b001}; // NOT 01
    vecs[22] = '{16'h8F70, 4'hF, 8'h00, 3'b110}; // INC FF wraps
    vecs[23] = '{16'h9D00, 4'hD, 8'hFF, 3'b011}; // DEC 0 borrows
    vecs[24] = '{16'hB123, 4'h1, 8'h04, 3'b011}; // NOP rd=1: nothing changes
  end

  initial begin
    rst_n        = 1'b0;
    inst         = 16'hB000;
    dbg_reg_sel  = 4'h0;
    dbg_mem_addr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state: every register and the flags read zero.
    for (int i = 0; i < 16; i++) begin
      dbg_reg_sel = 4'(i);
      #0;
      check8($sformatf("reset_x%0d", i), dbg_reg, 8'h00);
    end
    check8("reset_flags", {5'b0, flags}, 8'h00);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      exec(vecs[i].ins, vecs[i].sel, 8'h04);
      check8($sformatf("v%0d_reg", i), dbg_reg, vecs[i].exp_reg);
      check8($sformatf("v%0d_flags", i), {5'b0, flags}, {5'b0, exp_fl(vecs[i].exp_flags)});
    end

    // Memory after the ST in the table; the NOP left memory alone.
    check8("mem4_after_st", dbg_mem, 8'h0A);
    exec(16'hC100, 4'h1, 8'h04);                 // second NOP opcode
    check8("nopC_x1", dbg_reg, 8'h04);
    check8("nopC_flags", {5'b0, flags}, {5'b0, exp_fl(3'b011)});
    check8("nopC_mem4", dbg_mem, 8'h0A);

    // Place a known value in mem[0] for the reset-write-block check.
    exec(16'hF15A, 4'h1, 8'h00);                 // LDI x1=5A
    exec(16'hD001, 4'h1, 8'h00);                 // ST mem[x0=0]=x1
    check8("mem0_st", dbg_mem, 8'h5A);

    // Asynchronous reset between edges: state clears without a clock edge.
    @(negedge clk);
    inst        = 16'hD000;                      // ST mem[0]=0 if it could write
    dbg_reg_sel = 4'h1;
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_rst_x1", dbg_reg, 8'h00);
    check8("async_rst_flags", {5'b0, flags}, 8'h00);
    dbg_mem_addr = 8'h04;
    #0;
    check8("async_rst_mem4", dbg_mem, 8'h0A);

    // Hold reset across an edge: the pending ST must not write.
    @(posedge clk);
    #1;
    dbg_mem_addr = 8'h00;
    #0;
    check8("rst_blocks_st", dbg_mem, 8'h5A);

    // Release between edges; the very next edge executes normally.
    @(negedge clk);
    rst_n = 1'b1;
    inst  = 16'hF177;                            // LDI x1=77
    @(posedge clk);
    #1;
    dbg_reg_sel = 4'h1;
    #0;
    check8("first_edge_x1", dbg_reg, 8'h77);
    dbg_reg_sel = 4'h6;
    #0;
    check8("post_rst_x6", dbg_reg, 8'h00);

    // Overflow ADD after reset: flags set only when the flag register exists.
    exec(16'hF2FF, 4'h2, 8'h00);                 // LDI x2=FF
    exec(16'hF301, 4'h3, 8'h00);                 // LDI x3=01
    exec(16'h0423, 4'h4, 8'h00);                 // ADD x4=FF+01
    check8("ovf_x4", dbg_reg, 8'h00);
    check8("ovf_flags", {5'b0, flags}, {5'b0, exp_fl(3'b110)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
